i2c_slave_engine: RTL and testbench
===================================

I2C_SLAVE_ENGINE -- requirements
Module: i2c_slave_engine

Interface
REQ-001 Parameter: SDA_HOLD, default 3, CLK cycles between a detected SCL falling edge and any change of sda_out/sda_oe.
REQ-002 CLK  input  1  system clock, 12.288 MHz.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 address  input  7  this board's I2C address.
REQ-005 sda_i  input  1  de-glitched SDA.
REQ-006 scl_in  input  1  de-glitched SCL.
REQ-007 rcv_reg0 / rcv_reg1  input  8 each  read data, high byte / low byte.
REQ-008 sda_out  output  1  SDA drive value; 0 pulls low, 1 releases.
REQ-009 sda_oe  output  1  SDA output enable.
REQ-010 slave_addr  output  7  address captured from the last address byte.
REQ-011 int_reg0 / int_reg1  output  8 each  first / second written data byte.
REQ-012 wr_done  output  1  one-CLK pulse on STOP after at least one accepted write byte.
REQ-013 busy  output  1  high from START until STOP.

Function
REQ-014 Edge detection: scl_in and sda_i SHALL be registered once; all edges SHALL derive from the current vs. registered value.
REQ-015 START: sda_i falling while scl_in high; STOP: sda_i rising while scl_in high. Both SHALL be honoured in every state, STOP taking precedence.
REQ-016 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-017 START -> ADDR from any state (repeated start included); bit counter cleared; busy set.
REQ-018 Bits SHALL be sampled MSB first on SCL rising edges.
REQ-019 In ADDR, after the 8th bit: slave_addr <= bits[7:1] regardless of match; R/W = bit0.
REQ-020 Match (bits[7:1]==address): ACK by driving SDA low for the 9th clock -> WR_BYTE (W) or RD_BYTE (R). No match: SDA untouched -> WAIT_STOP.
REQ-021 WR_BYTE: byte index 0 -> int_reg0, index 1 -> int_reg1, updated on the 8th rising edge; ACK each; a 3rd byte SHALL be NACKed (SDA released) -> WAIT_STOP without updating registers.
REQ-022 RD_BYTE: rcv_reg0 and rcv_reg1 SHALL be latched together on the SCL falling edge ending ADDR_ACK; byte 0 = latched rcv_reg0, byte 1 = latched rcv_reg1, byte 2+ = 0xFF.
REQ-023 RD_ACK: master ACK (SDA low on 9th rising edge) -> next RD_BYTE; NACK -> WAIT_STOP with SDA released.
REQ-024 sda_oe/sda_out changes SHALL occur exactly SDA_HOLD CLK cycles after the SCL falling edge; SDA SHALL be released at the falling edge closing each ACK slot (slave ACK) and never driven while in IDLE or WAIT_STOP.
REQ-025 STOP -> IDLE, busy cleared, SDA released; wr_done pulses in that same cycle if byte index > 0 in a write transfer.
REQ-026 Byte index saturates at 2; bit counter 0..8, wraps to 0 after each ACK slot.

Reset
REQ-027 On rst: state IDLE, sda_oe 0, sda_out 1, slave_addr 0, int_reg0/1 0, wr_done 0, busy 0, counters 0, edge registers 1.
REQ-028 rst asserted mid-transfer SHALL release SDA immediately (asynchronous) and discard the partial byte.

Structure
REQ-029 Shared package holds the state enumeration, I2C_ADDR_W 7, I2C_BYTE_W 8, and the 0xFF idle-read constant.
REQ-030 One sub-module, i2c_edge_detect (scl/sda registration, START/STOP/SCL edge pulses); the state machine stays in i2c_slave_engine.

Verification
REQ-031 address=0x20; write 0x40,0xA5,0x3C,STOP -> all three ACKed, int_reg0=0xA5, int_reg1=0x3C, wr_done one pulse.
REQ-032 address=0x20, rcv_reg0=0x01, rcv_reg1=0x34; read 0x41, master ACK, NACK -> bytes 0x01,0x34 on SDA, slave_addr=0x20.
REQ-033 Address 0x42 sent with address=0x20 -> no ACK, SDA never driven, slave_addr=0x21, int_reg unchanged.
REQ-034 Write 0x40,0x11,0x22,0x33 -> third data byte NACKed, int_reg0=0x11, int_reg1=0x22.
REQ-035 Repeated START after 4 bits of a data byte, then read 0x41 -> clean read, partial byte discarded.
REQ-036 rst pulse during a slave ACK slot -> sda_oe 0 within the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/i2c_slave_engine_pkg.sv
// Shared definitions for the I2C slave engine.
//   I2C_ADDR_W   : width of a 7-bit I2C address
//   I2C_BYTE_W   : width of a data byte
//   RD_IDLE_BYTE : value returned for reads past the two data registers
//   state_t      : protocol state machine encoding
package i2c_slave_engine_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;

    localparam logic [I2C_BYTE_W-1:0] RD_IDLE_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrByte,
        StWrAck,
        StRdByte,
        StRdAck,
        StWaitStop
    } state_t;

endpackage

// File: rtl/i2c_edge_detect.sv
// Registers SCL and SDA once and derives single-cycle event pulses from the
// current versus registered values.
//   clk, rst          : system clock, asynchronous active-high reset
//   scl_in, sda_i     : de-glitched bus lines
//   scl_rise/scl_fall : SCL edge pulses
//   start_det         : SDA falling while SCL high
//   stop_det          : SDA rising while SCL high
module i2c_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_q;
    logic sda_q;

    // An idle bus is high, so the registers come out of reset at 1 to avoid
    // a spurious edge on the first cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_in;
            sda_q <= sda_i;
        end
    end

    always_comb begin
        scl_rise  = scl_in & ~scl_q;
        scl_fall  = ~scl_in & scl_q;
        start_det = scl_in & sda_q & ~sda_i;
        stop_det  = scl_in & ~sda_q & sda_i;
    end

endmodule

// File: rtl/i2c_slave_engine.sv
// I2C slave protocol engine: address match, two-byte write into int_reg0/1,
// read of rcv_reg0/1 (then 0xFF), with SDA changes delayed SDA_HOLD cycles
// after each SCL falling edge.
//   clk, rst               : system clock, asynchronous active-high reset
//   address                : own 7-bit address
//   sda_i, scl_in          : de-glitched bus lines
//   rcv_reg0, rcv_reg1     : read data (byte 0 / byte 1)
//   sda_out, sda_oe        : SDA drive value (0 pulls low) and enable
//   slave_addr             : address field of the last address byte
//   int_reg0, int_reg1     : first / second written data byte
//   wr_done                : one-cycle pulse on STOP after an accepted write
//   busy                   : high from START until STOP
module i2c_slave_engine
    import i2c_slave_engine_pkg::*;
#(
    parameter int unsigned SDA_HOLD = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [I2C_ADDR_W-1:0] address,
    input  logic                  sda_i,
    input  logic                  scl_in,
    input  logic [I2C_BYTE_W-1:0] rcv_reg0,
    input  logic [I2C_BYTE_W-1:0] rcv_reg1,
    output logic                  sda_out,
    output logic                  sda_oe,
    output logic [I2C_ADDR_W-1:0] slave_addr,
    output logic [I2C_BYTE_W-1:0] int_reg0,
    output logic [I2C_BYTE_W-1:0] int_reg1,
    output logic                  wr_done,
    output logic                  busy
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_edge_detect u_edge (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    state_t                  state;
    logic [3:0]              bit_cnt;   // 0..8; 8 means "inside the ACK slot"
    logic [1:0]              byte_idx;  // saturates at 2
    logic [I2C_ADDR_W-1:0]   shreg;     // first seven bits of the current byte
    logic                    rw;
    logic [I2C_BYTE_W-1:0]   rd_lat0;
    logic [I2C_BYTE_W-1:0]   rd_lat1;
    logic [7:0]              hold_cnt;
    logic                    pend_oe;
    logic                    pend_out;

    logic                    sched;
    logic                    sched_oe;
    logic                    sched_out;
    logic [I2C_BYTE_W-1:0]   tx_byte;

    always_comb begin
        case (byte_idx)
            2'd0:    tx_byte = rd_lat0;
            2'd1:    tx_byte = rd_lat1;
            default: tx_byte = RD_IDLE_BYTE;
        endcase
    end

    // SDA value to present after an SCL falling edge; applied SDA_HOLD later.
    always_comb begin
        sched     = 1'b0;
        sched_oe  = 1'b0;
        sched_out = 1'b1;
        if (scl_fall) begin
            case (state)
                StAddrAck: begin
                    sched = 1'b1;
                    if (bit_cnt == 4'd8) begin
                        sched_oe  = 1'b1;
                        sched_out = 1'b0;
                    end else if (rw) begin
                        // Closing the address ACK of a read: first bit of byte 0.
                        sched_oe  = 1'b1;
                        sched_out = rcv_reg0[7];
                    end
                end
                StWrAck: begin
                    sched = 1'b1;
                    if (bit_cnt == 4'd8) begin
                        sched_oe  = 1'b1;
                        sched_out = 1'b0;
                    end
                end
                StRdByte: begin
                    if (bit_cnt != 4'd0) begin
                        sched     = 1'b1;
                        sched_oe  = 1'b1;
                        sched_out = tx_byte[3'd7 - bit_cnt[2:0]];
                    end
                end
                StRdAck: begin
                    sched = 1'b1;
                    if (bit_cnt == 4'd0) begin
                        // Master ACKed; byte_idx already points at the next byte.
                        sched_oe  = 1'b1;
                        sched_out = tx_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            bit_cnt    <= 4'd0;
            byte_idx   <= 2'd0;
            shreg      <= '0;
            rw         <= 1'b0;
            rd_lat0    <= '0;
            rd_lat1    <= '0;
            hold_cnt   <= 8'd0;
            pend_oe    <= 1'b0;
            pend_out   <= 1'b1;
            sda_oe     <= 1'b0;
            sda_out    <= 1'b1;
            slave_addr <= '0;
            int_reg0   <= '0;
            int_reg1   <= '0;
            wr_done    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wr_done <= 1'b0;

            if (hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
                if (hold_cnt == 8'd1) begin
                    sda_oe  <= pend_oe;
                    sda_out <= pend_out;
                end
            end

            if (sched) begin
                if (SDA_HOLD == 0) begin
                    sda_oe  <= sched_oe;
                    sda_out <= sched_out;
                end else begin
                    hold_cnt <= 8'(SDA_HOLD);
                    pend_oe  <= sched_oe;
                    pend_out <= sched_out;
                end
            end

            // START/STOP release SDA at once and cancel any pending change.
            if (stop_det) begin
                wr_done  <= busy & ~rw & (byte_idx != 2'd0);
                state    <= StIdle;
                busy     <= 1'b0;
                bit_cnt  <= 4'd0;
                byte_idx <= 2'd0;
                hold_cnt <= 8'd0;
                sda_oe   <= 1'b0;
                sda_out  <= 1'b1;
            end else if (start_det) begin
                state    <= StAddr;
                busy     <= 1'b1;
                bit_cnt  <= 4'd0;
                byte_idx <= 2'd0;
                rw       <= 1'b0;
                hold_cnt <= 8'd0;
                sda_oe   <= 1'b0;
                sda_out  <= 1'b1;
            end else if (scl_rise) begin
                case (state)
                    StAddr: begin
                        shreg   <= {shreg[5:0], sda_i};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            slave_addr <= shreg;
                            rw         <= sda_i;
                            if (shreg == address) begin
                                state <= StAddrAck;
                            end else begin
                                state   <= StWaitStop;
                                bit_cnt <= 4'd0;
                            end
                        end
                    end
                    StAddrAck, StWrAck: bit_cnt <= 4'd0;
                    StWrByte: begin
                        shreg   <= {shreg[5:0], sda_i};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (byte_idx == 2'd0) begin
                                int_reg0 <= {shreg, sda_i};
                                byte_idx <= 2'd1;
                                state    <= StWrAck;
                            end else if (byte_idx == 2'd1) begin
                                int_reg1 <= {shreg, sda_i};
                                byte_idx <= 2'd2;
                                state    <= StWrAck;
                            end else begin
                                state   <= StWaitStop;
                                bit_cnt <= 4'd0;
                            end
                        end
                    end
                    StRdByte: begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state <= StRdAck;
                            if (byte_idx != 2'd2) begin
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end
                    end
                    StRdAck: begin
                        bit_cnt <= 4'd0;
                        if (sda_i) begin
                            state <= StWaitStop;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    StAddrAck: begin
                        if (bit_cnt == 4'd0) begin
                            if (rw) begin
                                rd_lat0 <= rcv_reg0;
                                rd_lat1 <= rcv_reg1;
                                state   <= StRdByte;
                            end else begin
                                state <= StWrByte;
                            end
                        end
                    end
                    StWrAck: if (bit_cnt == 4'd0) state <= StWrByte;
                    StRdAck: if (bit_cnt == 4'd0) state <= StRdByte;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_engine.sv
module tb_i2c_slave_engine;

    localparam int unsigned HOLD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] address = 7'h20;
    logic       m_sda = 1'b1;
    logic       scl = 1'b1;
    logic [7:0] rcv_reg0 = 8'h00;
    logic [7:0] rcv_reg1 = 8'h00;
    logic       sda_out;
    logic       sda_oe;
    logic [6:0] slave_addr;
    logic [7:0] int_reg0;
    logic [7:0] int_reg1;
    logic       wr_done;
    logic       busy;
    logic       sda_line;

    int checks = 0;
    int errors = 0;
    int oe_cycles = 0;
    int wr_done_cnt = 0;

    // Wired-AND bus: master and slave can each only pull low.
    assign sda_line = m_sda & (sda_oe ? sda_out : 1'b1);

    i2c_slave_engine #(.SDA_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .sda_i     (sda_line),
        .scl_in    (scl),
        .rcv_reg0  (rcv_reg0),
        .rcv_reg1  (rcv_reg1),
        .sda_out   (sda_out),
        .sda_oe    (sda_oe),
        .slave_addr(slave_addr),
        .int_reg0  (int_reg0),
        .int_reg1  (int_reg1),
        .wr_done   (wr_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sda_oe) oe_cycles <= oe_cycles + 1;
        if (wr_done) wr_done_cnt <= wr_done_cnt + 1;
    end

    task automatic master_start();
        @(negedge clk); m_sda = 1'b1;
        repeat (10) @(negedge clk); scl = 1'b1;
        repeat (10) @(negedge clk); m_sda = 1'b0;
        repeat (10) @(negedge clk); scl = 1'b0;
    endtask

    task automatic master_stop();
        @(negedge clk); m_sda = 1'b0;
        repeat (10) @(negedge clk); scl = 1'b1;
        repeat (10) @(negedge clk); m_sda = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Entered and left with SCL low.
    task automatic send_bit(input logic b);
        @(negedge clk); m_sda = b;
        repeat (9) @(negedge clk); scl = 1'b1;
        repeat (20) @(negedge clk); scl = 1'b0;
    endtask

    // ack: slave pulled SDA low in the 9th clock; lat: first negedge after the
    // 8th SCL fall at which sda_oe is seen high (0 if never).
    task automatic send_byte(input logic [7:0] data, output logic ack, output int lat);
        for (int i = 7; i >= 0; i--) send_bit(data[i]);
        m_sda = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (lat == 0 && sda_oe) lat = k;
        end
        scl = 1'b1;
        repeat (10) @(negedge clk);
        ack = ~sda_line;
        repeat (10) @(negedge clk); scl = 1'b0;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] data);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk); m_sda = 1'b1;
            repeat (9) @(negedge clk); scl = 1'b1;
            repeat (10) @(negedge clk);
            data[i] = sda_line;
            repeat (10) @(negedge clk); scl = 1'b0;
        end
        @(negedge clk); m_sda = ~master_ack;
        repeat (9) @(negedge clk); scl = 1'b1;
        repeat (20) @(negedge clk); scl = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        checks++; if (sda_out !== 1'b1) begin errors++; $display("FAIL reset_sda_out: got %b want 1", sda_out); end
        checks++; if (slave_addr !== 7'h00) begin errors++; $display("FAIL reset_slave_addr: got %h want 00", slave_addr); end
        checks++; if (int_reg0 !== 8'h00 || int_reg1 !== 8'h00) begin
            errors++; $display("FAIL reset_int_regs: got %h/%h want 00/00", int_reg0, int_reg1);
        end
        checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL reset_wr_done: got %b want 0", wr_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write();
        logic ack;
        int   lat;
        int   wd0;
        wd0 = wr_done_cnt;
        master_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_after_start: got %b want 1", busy); end
        send_byte(8'h40, ack, lat);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_addr_ack: got %b want 1", ack); end
        // One cycle to detect the SCL fall, then HOLD (3) cycles of delay.
        checks++; if (lat != 4) begin errors++; $display("FAIL wr_ack_hold_timing: got %0d want 4", lat); end
        send_byte(8'hA5, ack, lat);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_data0_ack: got %b want 1", ack); end
        send_byte(8'h3C, ack, lat);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_data1_ack: got %b want 1", ack); end
        master_stop();
        checks++; if (int_reg0 !== 8'hA5) begin errors++; $display("FAIL wr_int_reg0: got %h want a5", int_reg0); end
        checks++; if (int_reg1 !== 8'h3C) begin errors++; $display("FAIL wr_int_reg1: got %h want 3c", int_reg1); end
        checks++; if (wr_done_cnt - wd0 != 1) begin
            errors++; $display("FAIL wr_done_pulse: got %0d cycles want 1", wr_done_cnt - wd0);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
        checks++; if (slave_addr !== 7'h20) begin errors++; $display("FAIL wr_slave_addr: got %h want 20", slave_addr); end
    endtask

    task automatic test_read();
        logic       ack;
        int         lat;
        int         wd0;
        logic [7:0] d;
        wd0 = wr_done_cnt;
        rcv_reg0 = 8'h01;
        rcv_reg1 = 8'h34;
        master_start();
        send_byte(8'h41, ack, lat);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rd_addr_ack: got %b want 1", ack); end
        read_byte(1'b1, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL rd_byte0: got %h want 01", d); end
        // Latched at the end of the address ACK, so this must not show up.
        rcv_reg1 = 8'hEE;
        read_byte(1'b0, d);
        checks++; if (d !== 8'h34) begin errors++; $display("FAIL rd_byte1: got %h want 34", d); end
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_release_after_nack: got %b want 0", sda_oe); end
        master_stop();
        checks++; if (slave_addr !== 7'h20) begin errors++; $display("FAIL rd_slave_addr: got %h want 20", slave_addr); end
        checks++; if (wr_done_cnt != wd0) begin errors++; $display("FAIL rd_no_wr_done: got %0d want %0d", wr_done_cnt, wd0); end
    endtask

    task automatic test_no_match();
        logic ack;
        int   lat;
        int   oe0;
        int   wd0;
        oe0 = oe_cycles;
        wd0 = wr_done_cnt;
        master_start();
        send_byte(8'h42, ack, lat);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL nm_no_ack: got %b want 0", ack); end
        send_byte(8'h55, ack, lat);
        master_stop();
        checks++; if (oe_cycles != oe0) begin
            errors++; $display("FAIL nm_sda_never_driven: got %0d driven cycles want 0", oe_cycles - oe0);
        end
        checks++; if (slave_addr !== 7'h21) begin errors++; $display("FAIL nm_slave_addr: got %h want 21", slave_addr); end
        checks++; if (int_reg0 !== 8'hA5 || int_reg1 !== 8'h3C) begin
            errors++; $display("FAIL nm_int_regs: got %h/%h want a5/3c", int_reg0, int_reg1);
        end
        checks++; if (wr_done_cnt != wd0) begin errors++; $display("FAIL nm_no_wr_done: got %0d want %0d", wr_done_cnt, wd0); end
    endtask

    task automatic test_third_byte();
        logic ack;
        int   lat;
        int   wd0;
        wd0 = wr_done_cnt;
        master_start();
        send_byte(8'h40, ack, lat);
        send_byte(8'h11, ack, lat);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL tb_data0_ack: got %b want 1", ack); end
        send_byte(8'h22, ack, lat);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL tb_data1_ack: got %b want 1", ack); end
        send_byte(8'h33, ack, lat);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL tb_data2_nack: got ack %b want 0", ack); end
        master_stop();
        checks++; if (int_reg0 !== 8'h11 || int_reg1 !== 8'h22) begin
            errors++; $display("FAIL tb_int_regs: got %h/%h want 11/22", int_reg0, int_reg1);
        end
        checks++; if (wr_done_cnt - wd0 != 1) begin
            errors++; $display("FAIL tb_wr_done_pulse: got %0d cycles want 1", wr_done_cnt - wd0);
        end
    endtask

    task automatic test_repeated_start();
        logic       ack;
        int         lat;
        int         wd0;
        logic [7:0] d;
        wd0 = wr_done_cnt;
        rcv_reg0 = 8'h5A;
        rcv_reg1 = 8'hC3;
        master_start();
        send_byte(8'h40, ack, lat);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        master_start();
        send_byte(8'h41, ack, lat);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rs_addr_ack: got %b want 1", ack); end
        read_byte(1'b1, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rs_byte0: got %h want 5a", d); end
        read_byte(1'b0, d);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rs_byte1: got %h want c3", d); end
        master_stop();
        checks++; if (int_reg0 !== 8'h11 || int_reg1 !== 8'h22) begin
            errors++; $display("FAIL rs_partial_discarded: got %h/%h want 11/22", int_reg0, int_reg1);
        end
        checks++; if (wr_done_cnt != wd0) begin errors++; $display("FAIL rs_no_wr_done: got %0d want %0d", wr_done_cnt, wd0); end
    endtask

    task automatic test_reset_in_ack();
        master_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 6);  // 0x40
        m_sda = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (sda_oe !== 1'b1 || sda_line !== 1'b0) begin
            errors++; $display("FAIL ra_ack_active: got oe %b line %b want 1/0", sda_oe, sda_line);
        end
        rst = 1'b1;
        #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL ra_oe_async: got %b want 0", sda_oe); end
        checks++; if (sda_out !== 1'b1 || busy !== 1'b0 || wr_done !== 1'b0) begin
            errors++; $display("FAIL ra_ctrl: got out %b busy %b wr_done %b want 1/0/0", sda_out, busy, wr_done);
        end
        checks++; if (slave_addr !== 7'h00 || int_reg0 !== 8'h00 || int_reg1 !== 8'h00) begin
            errors++; $display("FAIL ra_regs: got %h %h %h want 00 00 00", slave_addr, int_reg0, int_reg1);
        end
        @(negedge clk); rst = 1'b0;
        master_stop();
        checks++; if (busy !== 1'b0 || sda_oe !== 1'b0) begin
            errors++; $display("FAIL ra_idle_after: got busy %b oe %b want 0/0", busy, sda_oe);
        end
    endtask

    initial begin
        repeat (4) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        test_write();
        test_read();
        test_no_match();
        test_third_byte();
        test_repeated_start();
        test_reset_in_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
